// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch and the
//   load/store path. One requester owns the port at a time. The arbiter
//   drives a request/ack handshake and returns one-cycle completion pulses
//   that the pipeline uses to stall. A fetch killed by if_flush still lets
//   its memory transaction finish, but no if_valid is reported for it.
//
// Ports
//   clk, rst_n                       core clock, async active-low reset
//   if_req/if_addr/if_flush          fetch request side
//   if_valid/if_rdata                fetch completion (pulse) and data
//   d_read/d_write/d_addr/d_wdata/d_wstrb   load/store request side
//   d_valid/d_rdata                  data completion (pulse) and load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   memory request, held until ack
//   mem_ack/mem_rdata                memory completion and read data
//
// state     | meaning
// ----------+-------------------------------------------
// S_IDLE    | no transaction, arbitration evaluated here
// S_IF_BUSY | fetch in flight
// S_D_BUSY  | data access in flight
// S_IF_DROP | flushed fetch in flight, its ack is dropped

module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_read,
  input  logic            d_write,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_D_BUSY  = 2'd2,
    S_IF_DROP = 2'd3
  } state_e;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  state_e            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;

  logic d_pend, f_pend, grant_f, grant_d;

  always_comb begin
    d_pend      = d_read | d_write;
    f_pend      = if_req & ~if_flush;
    grant_f     = 1'b0;
    grant_d     = 1'b0;
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      S_IDLE: begin
        // Data has priority unless it has already won RUN_MAX grants in a
        // row while the fetch was waiting.
        if (f_pend && (!d_pend || run_q == RUN_MAX)) begin
          grant_f = 1'b1;
        end else if (d_pend) begin
          grant_d = 1'b1;
        end

        if (grant_f) begin
          state_d     = S_IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = 4'h0;
        end else if (grant_d) begin
          // Read and write together resolve as a write.
          state_d     = S_D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_write ? d_wstrb : 4'h0;
        end
      end
      S_IF_BUSY: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end else if (if_flush) begin
          state_d = S_IF_DROP;
        end
      end
      S_D_BUSY, S_IF_DROP: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!if_req || grant_f) begin
      run_d = 4'd0;
    end else if (grant_d && run_q < RUN_MAX) begin
      run_d = run_q + 4'd1;
    end else begin
      run_d = run_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      run_q       <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Completion is taken straight from mem_ack so the pipeline can release
  // its stall in the ack cycle.
  assign if_valid  = mem_ack & (state_q == S_IF_BUSY) & ~if_flush;
  assign d_valid   = mem_ack & (state_q == S_D_BUSY);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a port-ownership reference model.

module tb_mem_port_arbiter;
  localparam int XLEN    = 32;
  localparam int MAX_RUN = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_req, if_flush, if_valid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            d_read, d_write, d_valid;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]      d_wstrb;
  logic            mem_req, mem_we, mem_ack;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always @(negedge clk) begin
    if (rst_n) assert (!(d_read && d_write)) else $error("illegal: d_read and d_write both high");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 data,
  // 3 flushed fetch), the request the memory should be seeing, and how many
  // data grants have been made in a row while a fetch kept waiting.
  int              owner;
  logic            e_req, e_we;
  logic [XLEN-1:0] e_addr, e_wdata;
  logic [3:0]      e_wstrb;
  int              streak;
  logic            exp_if_v, exp_d_v;
  logic            last_if_v, last_d_v, last_flush;

  // Memory responder and observation state
  int              ack_cnt, lat_cur, fix_lat;
  bit              rand_lat, rand_rdata, spurious;
  logic [XLEN-1:0] fixed_rdata;
  logic [XLEN-1:0] grant_log[$];
  logic            prev_req;
  logic            obs_if_v, obs_d_v;
  int              if_v_seen, d_v_seen;

  task automatic model_reset();
    owner = 0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
    streak = 0; exp_if_v = 0; exp_d_v = 0;
    last_if_v = 0; last_d_v = 0; last_flush = 0;
    ack_cnt = 0; prev_req = 0;
  endtask

  function automatic logic [XLEN-1:0] log_at(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 32'hDEAD_DEAD;
  endfunction

  // One clock cycle. Entered just after a falling edge with the requester
  // inputs already set; returns at the next falling edge.
  task automatic step();
    bit d_pend, f_pend, g_f, g_d;
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      if (ack_cnt >= lat_cur) begin
        mem_ack = 1'b1;
        ack_cnt = 0;
        lat_cur = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
      if (spurious && $urandom_range(0, 15) == 0) mem_ack = 1'b1;
    end
    mem_rdata = rand_rdata ? $urandom : fixed_rdata;
    #1;
    if (mem_req === 1'b1 && prev_req !== 1'b1) grant_log.push_back(mem_addr);
    prev_req = mem_req;
    obs_if_v = if_valid;
    obs_d_v  = d_valid;
    if (if_valid === 1'b1) if_v_seen++;
    if (d_valid === 1'b1) d_v_seen++;

    exp_if_v = mem_ack && owner == 1 && !if_flush;
    exp_d_v  = mem_ack && owner == 2;
    check_eq("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) begin
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_we", 32'(mem_we), 32'(e_we));
      check_eq("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      if (e_we) check_eq("mem_wdata", mem_wdata, e_wdata);
    end
    check_eq("if_valid", 32'(if_valid), 32'(exp_if_v));
    check_eq("d_valid", 32'(d_valid), 32'(exp_d_v));
    if (exp_if_v) check_eq("if_rdata", if_rdata, mem_rdata);
    if (exp_d_v) check_eq("d_rdata", d_rdata, mem_rdata);

    d_pend = d_read || d_write;
    f_pend = if_req && !if_flush;
    g_f = 0; g_d = 0;
    if (owner == 0) begin
      if (f_pend && (!d_pend || streak == MAX_RUN)) g_f = 1;
      else if (d_pend) g_d = 1;
      if (g_f) begin
        owner = 1; e_req = 1; e_we = 0; e_addr = if_addr; e_wstrb = 4'h0;
      end else if (g_d) begin
        owner = 2; e_req = 1; e_we = d_write; e_addr = d_addr; e_wdata = d_wdata;
        e_wstrb = d_write ? d_wstrb : 4'h0;
      end
    end else if (mem_ack) begin
      owner = 0; e_req = 0;
    end else if (owner == 1 && if_flush) begin
      owner = 3;
    end
    if (!if_req || g_f) streak = 0;
    else if (g_d) streak = (streak < MAX_RUN) ? streak + 1 : MAX_RUN;

    last_if_v = exp_if_v; last_d_v = exp_d_v; last_flush = if_flush;
    @(negedge clk);
  endtask

  task automatic set_lat(input int l);
    fix_lat = l; lat_cur = l;
  endtask

  task automatic drain();
    if_req = 0; if_flush = 0; d_read = 0; d_write = 0;
    for (int k = 0; k < 20 && (owner != 0 || mem_req === 1'b1); k++) step();
    step();
  endtask

  task automatic drive_random();
    if_flush = 0;
    if (if_req && (last_if_v || last_flush)) if_req = 0;
    if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (if_req && $urandom_range(0, 19) == 0) begin
      if_flush = 1;
    end
    if ((d_read || d_write) && last_d_v) begin d_read = 0; d_write = 0; end
    if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 1) == 1) begin
        d_write = 1; d_wstrb = 4'($urandom_range(1, 15));
      end else begin
        d_read = 1; d_wstrb = 4'($urandom);
      end
      d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
    end
  endtask

  initial begin
    int hit;
    bit found;
    logic [XLEN-1:0] starve_exp[6];

    rst_n = 0; if_req = 0; if_addr = '0; if_flush = 0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ack = 0; mem_rdata = '0;
    rand_lat = 0; rand_rdata = 0; spurious = 0; fixed_rdata = '0;
    set_lat(3); if_v_seen = 0; d_v_seen = 0;
    model_reset();

    // Reset values
    #22;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_d_valid", 32'(d_valid), 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();

    // Single fetch, ack three cycles after mem_req
    fixed_rdata = 32'h0050_0093; set_lat(3); grant_log.delete();
    if_req = 1; if_addr = 32'h100; hit = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_if_v === 1'b1) begin hit = k; break; end
    end
    check_eq("fetch_valid_cycle", 32'(hit), 32'd4);
    check_eq("fetch_grant_addr", log_at(0), 32'h100);
    drain();

    // Store, one d_valid pulse
    set_lat(2); grant_log.delete(); d_v_seen = 0;
    d_write = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    for (int k = 0; k < 20 && obs_d_v !== 1'b1; k++) step();
    d_write = 0;
    for (int k = 0; k < 4; k++) step();
    check_eq("store_dvalid_pulses", 32'(d_v_seen), 32'd1);
    check_eq("store_grant_addr", log_at(0), 32'h2000);
    drain();

    // Anti-starvation: fetch held with a continuous load stream
    set_lat(1); grant_log.delete();
    if_req = 1; if_addr = 32'h100; d_read = 1; d_addr = 32'h3000;
    for (int k = 0; k < 40; k++) step();
    starve_exp = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h100, 32'h3000};
    for (int i = 0; i < 6; i++) check_eq($sformatf("starve_order%0d", i), log_at(i), starve_exp[i]);
    drain();

    // Flush while the fetch is in flight
    set_lat(3); grant_log.delete(); if_v_seen = 0;
    if_req = 1; if_addr = 32'h300;
    step(); step();
    if_flush = 1;
    step();
    if_flush = 0; if_addr = 32'h200;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (grant_log.size() > 1 && grant_log[1] == 32'h200) found = 1;
    end
    check_eq("flush_no_valid", 32'(if_v_seen), 32'd0);
    check_eq("flush_next_grant", 32'(found), 32'd1);
    for (int k = 0; k < 20 && obs_if_v !== 1'b1; k++) step();
    check_eq("flush_next_valid", 32'(if_v_seen), 32'd1);
    drain();

    // Flush in the same cycle as mem_ack
    set_lat(0); if_v_seen = 0;
    if_req = 1; if_addr = 32'h400;
    step();
    if_flush = 1;
    step();
    check_eq("coinc_if_valid", 32'(obs_if_v), 32'd0);
    if_flush = 0; if_req = 0;
    step();
    check_eq("coinc_idle_req", 32'(prev_req), 32'd0);
    drain();

    // Asynchronous reset during a data access
    set_lat(5); d_v_seen = 0;
    d_read = 1; d_addr = 32'h5000;
    step(); step();
    #2 rst_n = 0;
    #1;
    check_eq("async_rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("async_rst_mem_addr", mem_addr, 32'd0);
    d_read = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 8; k++) step();
    check_eq("async_rst_no_dvalid", 32'(d_v_seen), 32'd0);

    // Randomized traffic
    rand_lat = 1; rand_rdata = 1; spurious = 1; lat_cur = 1;
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch stage and the MEM-stage load/store path of the pipelined RV32I core.
- Grants the port to one requester at a time and drives the multi-cycle memory handshake.
- Returns data and completion pulses that the pipeline uses to stall.
- Drops fetch responses killed by a pipeline flush.

Parameters:
- XLEN, 32, address/data width
- MAX_DATA_RUN, 4, maximum consecutive data grants while a fetch is pending before fetch must win one grant (range 1..15)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level-held until if_valid or flush
- if_addr  in  XLEN  fetch address, stable while if_req high
- if_flush  in  1  one-cycle pulse, kills the outstanding or pending fetch
- if_valid  out  1  fetch complete, one-cycle pulse
- if_rdata  out  XLEN  instruction word, meaningful only while if_valid
- d_read  in  1  load request (MemRead), level-held until d_valid
- d_write  in  1  store request (MemWrite), level-held until d_valid
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_wstrb  in  4  byte enables for the store
- d_valid  out  1  data access complete, one-cycle pulse; also pulses for stores
- d_rdata  out  XLEN  load data, meaningful only while d_valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_wstrb  out  4  memory byte enables, 0 for reads
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
- Reset, asynchronous: state IDLE; run counter 0; mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are 0. if_valid and d_valid are 0.
- FSM states:
  - IDLE: no transaction
  - IF_BUSY: fetch in flight
  - D_BUSY: data access in flight
  - IF_DROP: flushed fetch in flight
- IDLE arbitration, evaluated each cycle in IDLE:
  - Data access (d_read or d_write) and fetch (if_req and not if_flush) both pending:
    - If run counter == MAX_DATA_RUN, grant fetch.
    - Otherwise, grant data.
  - Only one requester pending: grant it.
  - Nothing pending: stay in IDLE.
- Grant handling:
  - The grant registers mem_addr, mem_we, mem_wdata and mem_wstrb from the granted requester.
  - It sets mem_req on the next clock edge. Latency from request to mem_req is 1 cycle.
  - Next state is IF_BUSY or D_BUSY.
- Run counter:
  - Increments on each data grant made while if_req is high.
  - Clears on a fetch grant, or in any cycle where if_req is low.
  - Saturates at MAX_DATA_RUN.
- d_read and d_write both high: treated as a write (mem_we=1). A bench assertion flags this case as illegal.
- mem_req and the mem_* fields stay stable until the cycle mem_ack is high. mem_req deasserts on the edge after mem_ack.
- Completion is combinational from mem_ack:
  - if_valid = mem_ack and state == IF_BUSY and not if_flush
  - d_valid = mem_ack and state == D_BUSY
  - if_rdata and d_rdata pass mem_rdata through.
- After mem_ack the FSM returns to IDLE. New arbitration happens in that IDLE cycle, so back-to-back transactions are separated by one idle cycle.
- Requesters must drop or change their request on the edge after their valid pulse.
- if_flush handling:
  - In IF_BUSY without mem_ack: go to IF_DROP. The memory transaction runs to completion, and its mem_ack produces no if_valid.
  - In IF_BUSY with mem_ack in the same cycle: if_valid is suppressed and the FSM goes to IDLE.
  - In IDLE: the fetch is not granted that cycle.
  - In D_BUSY: no effect.
- mem_ack outside IF_BUSY, D_BUSY or IF_DROP is ignored.
- Reset mid-transaction clears everything immediately. The memory is expected to be reset by the same rst_n.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ack 3 cycles after mem_req -> mem_req=1 one cycle after if_req with mem_addr=0x100 and mem_we=0; if_valid pulses in the ack cycle with if_rdata=mem_rdata=0x00500093.
- Store: d_write=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_we=1 and mem_wstrb=0xF, held stable until ack; d_valid pulses for one cycle.
- Priority and anti-starvation with MAX_DATA_RUN=4: if_req held with continuous d_read -> grant order D,D,D,D,IF,D...
- Flush in flight: fetch granted, if_flush pulsed before mem_ack -> state IF_DROP; no if_valid on the ack; the next if_req at 0x200 is granted afterwards.
- Flush coincident with mem_ack: if_valid stays 0 and the FSM goes to IDLE the next cycle.
- Async reset asserted in D_BUSY -> mem_req=0 and state IDLE immediately, without a clock edge; no d_valid after release.
